// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift, rotate, load and clear,
// plus an auto-shift sequencer that repeats a shift/rotate a programmed number of times.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rest,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNTW-1:0]  shamt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_SHR   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_CLR   = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [CNTW-1:0]  cnt_q;
  logic [2:0]       op_q;
  logic             busy_q;
  logic             done_q;
  logic             auto_op_c;

  // Next register value for one application of an operation.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (op)
      M_SHL:   nxt = {cur[WIDTH-2:0], sr};
      M_SHR:   nxt = {sl, cur[WIDTH-1:1]};
      M_LOAD:  nxt = ld;
      M_ROL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:   nxt = {cur[0], cur[WIDTH-1:1]};
      M_CLR:   nxt = '0;
      M_HOLD:  nxt = cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  assign auto_op_c = (mode == M_SHL) || (mode == M_SHR) ||
                     (mode == M_ROL) || (mode == M_ROR);

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      op_q    <= M_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && auto_op_c) begin
            // q holds on the accept edge; shifting starts on the next one.
            if (shamt != '0) begin
              op_q    <= mode;
              cnt_q   <= shamt;
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            q_q <= apply_op(mode, q_q, d, sin_l, sin_r);
          end
        end
        S_RUN: begin
          q_q   <= apply_op(op_q, q_q, d, sin_l, sin_r);
          cnt_q <= cnt_q - CNTW'(1);
          if (cnt_q <= CNTW'(1)) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with hand-computed expectations.
module tb_univ_shift_reg;

  logic       clk;
  logic       rest;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [3:0] shamt;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int unsigned n_chk;
  int unsigned n_bad;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk    (clk),
    .rest   (rest),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .shamt  (shamt),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".busy"}, 8'(busy), 8'(eb));
    chk({tag, ".done"}, 8'(done), 8'(ed));
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rest = 1'b1; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    start = 1'b0; shamt = 4'd0;
    tick(); tick();

    // Reset with a load still requested
    rest = 1'b0; mode = 3'b011; d = 8'hA5;
    tick();
    chk("pre_rst_load", q, 8'hA5);
    rest = 1'b1;
    tick();
    chk_st("rst", 8'h00, 1'b0, 1'b0);
    chk("rst.sout_l", 8'(sout_l), 8'h00);
    chk("rst.sout_r", 8'(sout_r), 8'h00);

    // Single-cycle operations
    rest = 1'b0; mode = 3'b011; d = 8'hA5;
    tick(); chk("load", q, 8'hA5);
    mode = 3'b001; sin_r = 1'b1;
    tick(); chk("shl", q, 8'h4B);
    mode = 3'b010; sin_l = 1'b0;
    tick(); chk("shr", q, 8'h25);
    chk("shr.sout_l", 8'(sout_l), 8'h00);
    chk("shr.sout_r", 8'(sout_r), 8'h01);
    mode = 3'b100;
    tick(); chk("rol", q, 8'h4A);
    mode = 3'b101;
    tick(); chk("ror", q, 8'h25);
    mode = 3'b010; sin_l = 1'b1;
    tick(); chk("shr_sin1", q, 8'h92);
    chk("shr_sin1.sout_l", 8'(sout_l), 8'h01);
    mode = 3'b000;
    tick(); chk("hold0", q, 8'h92);
    mode = 3'b111;
    tick(); chk("hold7", q, 8'h92);
    mode = 3'b110;
    tick(); chk_st("clr", 8'h00, 1'b0, 1'b0);

    // Auto rotate left 0x81 by 3
    mode = 3'b011; d = 8'h81;
    tick();
    start = 1'b1; mode = 3'b100; shamt = 4'd3;
    tick(); chk_st("arol.acc", 8'h81, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    tick(); chk_st("arol.1", 8'h03, 1'b1, 1'b0);
    tick(); chk_st("arol.2", 8'h06, 1'b1, 1'b0);
    tick(); chk_st("arol.3", 8'h0C, 1'b0, 1'b1);
    tick(); chk_st("arol.post", 8'h0C, 1'b0, 1'b0);
    tick(); chk_st("arol.post2", 8'h0C, 1'b0, 1'b0);

    // Auto rotate right 0x5A by 8 while a load is requested
    mode = 3'b011; d = 8'h5A;
    tick();
    start = 1'b1; mode = 3'b101; shamt = 4'd8;
    tick(); chk_st("aror.acc", 8'h5A, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b011; d = 8'hFF;
    tick(); chk_st("aror.1", 8'h2D, 1'b1, 1'b0);
    for (int i = 2; i < 8; i++) begin
      tick(); chk("aror.busy", 8'(busy), 8'h01);
    end
    tick(); chk_st("aror.done", 8'h5A, 1'b0, 1'b1);
    mode = 3'b000;
    tick(); chk_st("aror.post", 8'h5A, 1'b0, 1'b0);

    // Degenerate starts
    start = 1'b1; mode = 3'b010; shamt = 4'd0;
    tick(); chk_st("sh0", 8'h5A, 1'b0, 1'b1);
    start = 1'b0; mode = 3'b000;
    tick(); chk_st("sh0.post", 8'h5A, 1'b0, 1'b0);
    start = 1'b1; mode = 3'b011; d = 8'h3C; shamt = 4'd4;
    tick(); chk_st("start_load", 8'h3C, 1'b0, 1'b0);
    start = 1'b0; mode = 3'b000;

    // Shift left by more than WIDTH: all serial ones end up in q
    mode = 3'b110;
    tick();
    start = 1'b1; mode = 3'b001; shamt = 4'd10; sin_r = 1'b1;
    tick(); chk_st("big.acc", 8'h00, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    for (int i = 1; i < 10; i++) tick();
    chk_st("big.9", 8'hFF, 1'b1, 1'b0);
    tick(); chk_st("big.done", 8'hFF, 1'b0, 1'b1);
    tick();

    // Abort by reset on the 2nd RUN edge
    mode = 3'b011; d = 8'hFF;
    tick();
    start = 1'b1; mode = 3'b001; shamt = 4'd5; sin_r = 1'b0;
    tick(); chk_st("abort.acc", 8'hFF, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    tick(); chk_st("abort.1", 8'hFE, 1'b1, 1'b0);
    rest = 1'b1;
    tick(); chk_st("abort.rst", 8'h00, 1'b0, 1'b0);
    rest = 1'b0;
    tick(); chk_st("abort.post", 8'h00, 1'b0, 1'b0);
    tick(); chk_st("abort.post2", 8'h00, 1'b0, 1'b0);

    // Start asserted during DONE is ignored
    mode = 3'b011; d = 8'h01;
    tick();
    start = 1'b1; mode = 3'b100; shamt = 4'd1;
    tick(); chk_st("ign.acc", 8'h01, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    tick(); chk_st("ign.done", 8'h02, 1'b0, 1'b1);
    start = 1'b1; mode = 3'b100; shamt = 4'd2;
    tick(); chk_st("ign.start", 8'h02, 1'b0, 1'b0);
    start = 1'b0; mode = 3'b000;
    tick(); chk_st("ign.post", 8'h02, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
